// File: rtl/traffic_controller.sv
// traffic_controller: game-state FSM, enemy respawn scheduling and scoring.
// Optional feature macro: SCORE_SPEEDUP_EN (raises speed_level every 16 points).
module traffic_controller #(
  parameter int unsigned OFFSCREEN_Y = 600,
  parameter int unsigned MIN_GAP     = 130,
  parameter int unsigned CRASH_HOLD  = 200,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       enemy_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] enemy_y0,
  input  logic [9:0] enemy_y1,
  input  logic       collision0,
  input  logic       collision1,
  output logic       enable0,
  output logic       enable1,
  output logic [1:0] lane0,
  output logic [1:0] lane1,
  output logic [9:0] spawn_x0,
  output logic [9:0] spawn_x1,
  output logic       freeze,
  output logic       game_over,
  output logic [9:0] score,
  output logic [1:0] speed_level
);

  localparam int unsigned CW        = (CRASH_HOLD > 1) ? $clog2(CRASH_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(CRASH_HOLD - 1);
  localparam logic [9:0] OFF_Y      = 10'(OFFSCREEN_Y);
  localparam logic [9:0] GAP_Y      = 10'(MIN_GAP);
  localparam logic [9:0] SCORE_MAX  = 10'd999;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CRASH = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          en0_q, en0_d, en1_q, en1_d;
  logic [1:0]    lane0_q, lane0_d, lane1_q, lane1_d;
  logic          armed0_q, armed0_d, armed1_q, armed1_d;
  logic [9:0]    score_q, score_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          qual0, qual1, bump;
  logic [1:0]    cand, pick0, pick1;
`ifdef SCORE_SPEEDUP_EN
  logic [1:0]    speed_q, speed_d;
`endif

  function automatic logic [1:0] lane_step(input logic [1:0] l);
    return (l == 2'd2) ? 2'd0 : l + 2'd1;
  endfunction

  function automatic logic [9:0] lane_x(input logic [1:0] l);
    case (l)
      2'd0:    return 10'd197;
      2'd2:    return 10'd361;
      default: return 10'd279;
    endcase
  endfunction

  // Next-state, respawn arbitration, lane choice and scoring
  always_comb begin
    state_d  = state_q;
    en0_d    = 1'b0;
    en1_d    = 1'b0;
    lane0_d  = lane0_q;
    lane1_d  = lane1_q;
    score_d  = score_q;
    cnt_d    = cnt_q;
    bump     = 1'b0;
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    armed0_d = armed0_q | (enemy_y0 < OFF_Y);
    armed1_d = armed1_q | (enemy_y1 < OFF_Y);
    qual0    = armed0_q && (enemy_y0 >= OFF_Y);
    qual1    = armed1_q && (enemy_y1 >= OFF_Y);
    cand     = (lfsr_q[1:0] == 2'd3) ? 2'd1 : lfsr_q[1:0];
    pick0    = ((enemy_y1 < GAP_Y) && (cand == lane1_q)) ? lane_step(cand) : cand;
    pick1    = ((enemy_y0 < GAP_Y) && (cand == lane0_q)) ? lane_step(cand) : cand;
`ifdef SCORE_SPEEDUP_EN
    speed_d  = speed_q;
`endif

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_RUN;
          score_d = '0;
`ifdef SCORE_SPEEDUP_EN
          speed_d = '0;
`endif
        end
      end
      S_RUN: begin
        // A collision pre-empts any respawn decided in the same cycle
        if (collision0 || collision1) begin
          state_d = S_CRASH;
          cnt_d   = '0;
        end else if (qual0) begin
          en0_d    = 1'b1;
          armed0_d = 1'b0;
          lane0_d  = pick0;
          bump     = 1'b1;
        end else if (qual1) begin
          en1_d    = 1'b1;
          armed1_d = 1'b0;
          lane1_d  = pick1;
          bump     = 1'b1;
        end
      end
      S_CRASH: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_OVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bump && (score_q != SCORE_MAX)) begin
      score_d = score_q + 10'd1;
`ifdef SCORE_SPEEDUP_EN
      if ((score_d[3:0] == 4'd0) && (speed_q != 2'd3)) begin
        speed_d = speed_q + 2'd1;
      end
`endif
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge enemy_clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      en0_q    <= 1'b0;
      en1_q    <= 1'b0;
      lane0_q  <= 2'd0;
      lane1_q  <= 2'd2;
      armed0_q <= 1'b1;
      armed1_q <= 1'b1;
      score_q  <= '0;
      lfsr_q   <= LFSR_SEED;
      cnt_q    <= '0;
`ifdef SCORE_SPEEDUP_EN
      speed_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      en0_q    <= en0_d;
      en1_q    <= en1_d;
      lane0_q  <= lane0_d;
      lane1_q  <= lane1_d;
      armed0_q <= armed0_d;
      armed1_q <= armed1_d;
      score_q  <= score_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
`ifdef SCORE_SPEEDUP_EN
      speed_q  <= speed_d;
`endif
    end
  end

  assign enable0   = en0_q;
  assign enable1   = en1_q;
  assign lane0     = lane0_q;
  assign lane1     = lane1_q;
  assign spawn_x0  = lane_x(lane0_q);
  assign spawn_x1  = lane_x(lane1_q);
  assign freeze    = (state_q != S_RUN);
  assign game_over = (state_q == S_CRASH) || (state_q == S_OVER);
  assign score     = score_q;
`ifdef SCORE_SPEEDUP_EN
  assign speed_level = speed_q;
`else
  assign speed_level = '0;
`endif

endmodule

// File: tb/tb_traffic_controller.sv
// Directed self-checking bench for traffic_controller.
module tb_traffic_controller;

  localparam logic [7:0] SEED = 8'hA5;
  localparam int unsigned GAP = 130;
`ifdef SCORE_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, col0, col1;
  logic [9:0] y0, y1;
  logic       en0, en1, freeze, game_over;
  logic [1:0] lane0, lane1, speed_level;
  logic [9:0] sx0, sx1, score;

  traffic_controller #(
    .OFFSCREEN_Y(600),
    .MIN_GAP    (130),
    .CRASH_HOLD (200),
    .LFSR_SEED  (SEED)
  ) dut (
    .enemy_clk  (clk),
    .reset      (reset),
    .start      (start),
    .enemy_y0   (y0),
    .enemy_y1   (y1),
    .collision0 (col0),
    .collision1 (col1),
    .enable0    (en0),
    .enable1    (en1),
    .lane0      (lane0),
    .lane1      (lane1),
    .spawn_x0   (sx0),
    .spawn_x1   (sx1),
    .freeze     (freeze),
    .game_over  (game_over),
    .score      (score),
    .speed_level(speed_level)
  );

  always #5 clk = ~clk;

  // Reference LFSR; m_prev holds the value the DUT used at the last edge
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  int n_checks = 0;
  int n_fail   = 0;
  int exp_score, exp_speed;
  logic [1:0] exp_lane0, exp_lane1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] pick(input logic [7:0] l, input logic [9:0] oy,
                                      input logic [1:0] ol);
    logic [1:0] c;
    c = (l[1:0] == 2'd3) ? 2'd1 : l[1:0];
    if ((oy < 10'(GAP)) && (c == ol)) c = (c == 2'd2) ? 2'd0 : c + 2'd1;
    return c;
  endfunction

  function automatic int xpos(input logic [1:0] l);
    return 197 + 82 * int'(l);
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_en0"}, en0, 0);
    check({tag, "_en1"}, en1, 0);
    check({tag, "_lane0"}, lane0, 0);
    check({tag, "_lane1"}, lane1, 2);
    check({tag, "_sx0"}, sx0, 197);
    check({tag, "_sx1"}, sx1, 361);
    check({tag, "_score"}, score, 0);
    check({tag, "_freeze"}, freeze, 1);
    check({tag, "_gameover"}, game_over, 0);
    check({tag, "_speed"}, speed_level, 0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
    exp_score = 0;
    exp_speed = 0;
    exp_lane0 = 2'd0;
    exp_lane1 = 2'd2;
  endtask

  // One edge at which slot s is expected to pulse
  task automatic step_fire(input int s);
    tick();
    if (s == 0) exp_lane0 = pick(m_prev, y1, exp_lane1);
    else        exp_lane1 = pick(m_prev, y0, exp_lane0);
    if (exp_score < 999) begin
      exp_score++;
      if (SPEEDUP && (exp_score % 16 == 0) && (exp_speed < 3)) exp_speed++;
    end
    check("fire_en0", en0, (s == 0));
    check("fire_en1", en1, (s == 1));
    check("fire_lane0", lane0, exp_lane0);
    check("fire_lane1", lane1, exp_lane1);
    check("fire_sx0", sx0, xpos(exp_lane0));
    check("fire_sx1", sx1, xpos(exp_lane1));
    check("fire_score", score, exp_score);
    check("fire_speed", speed_level, exp_speed);
  endtask

  task automatic step_quiet();
    tick();
    check("quiet_en0", en0, 0);
    check("quiet_en1", en1, 0);
    check("quiet_score", score, exp_score);
  endtask

  task automatic enter_run(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_score = 0;
    exp_speed = 0;
    check({tag, "_freeze"}, freeze, 0);
    check({tag, "_gameover"}, game_over, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_speed"}, speed_level, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; col0 = 1'b0; col1 = 1'b0;
    y0 = 10'd0; y1 = 10'd0;

    do_reset(2);
    check_reset_vals("rst");
    tick();
    check("idle_freeze", freeze, 1);
    enter_run("run1");

    // Single respawn, held offscreen, re-arm, second respawn
    y0 = 10'd600;
    step_fire(0);
    repeat (4) step_quiet();
    y0 = 10'd0;
    step_quiet();
    y0 = 10'd600;
    step_fire(0);
    y0 = 10'd0;
    step_quiet();

    // Both slots qualify together: slot0 then slot1
    y0 = 10'd650; y1 = 10'd650;
    step_fire(0);
    step_fire(1);
    y0 = 10'd0; y1 = 10'd0;
    step_quiet();

    // Steer lane1 to the center lane
    for (int i = 0; i < 64 && exp_lane1 != 2'd1; i++) begin
      y1 = 10'd650;
      step_fire(1);
      y1 = 10'd0;
      step_quiet();
    end
    check("lane1_center", lane1, 1);

    // Slot1 near the top in lane 1: slot0 must never pick lane 1
    y1 = 10'd50;
    for (int i = 0; i < 300; i++) begin
      y0 = 10'd600;
      step_fire(0);
      check("lane0_blocked", (lane0 == 2'd1), 0);
      y0 = 10'd0;
      step_quiet();
    end

    // Drive score into saturation
    y1 = 10'd0;
    for (int i = 0; i < 720; i++) begin
      y0 = 10'd600;
      step_fire(0);
      y0 = 10'd0;
      step_quiet();
    end
    check("score_sat", score, 999);

    // Collision beats a same-cycle respawn; CRASH lasts 200 cycles
    y0 = 10'd600; col1 = 1'b1;
    tick();
    col1 = 1'b0;
    check("col_en0", en0, 0);
    check("col_score", score, 999);
    check("col_gameover", game_over, 1);
    check("col_freeze", freeze, 1);
    repeat (199) tick();
    check("crash_en0", en0, 0);
    check("crash_gameover", game_over, 1);
    start = 1'b1;
    tick();
    check("crash_start_ignored", freeze, 1);
    check("over_gameover", game_over, 1);
    enter_run("run2");
    step_fire(0);
    y0 = 10'd0;
    step_quiet();

    // Reset mid-CRASH
    col0 = 1'b1;
    tick();
    col0 = 1'b0;
    check("crash2_gameover", game_over, 1);
    repeat (50) tick();
    do_reset(1);
    check_reset_vals("rst2");
    enter_run("run3");

    // Long run from zero: speed level saturates only with the feature built in
    for (int i = 0; i < 50; i++) begin
      y0 = 10'd600;
      step_fire(0);
      y0 = 10'd0;
      step_quiet();
    end
    check("speed_final", speed_level, SPEEDUP ? 3 : 0);
    check("score_final", score, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
